// File: rtl/writeback.sv
// rtl/writeback.sv - write-back stage driving the register-file write port (optional forwarding: WB_FORWARD_EN)

`ifndef RTYPE
`define RTYPE  5'd1
`define ITYPE  5'd2
`define STYPE  5'd3
`define BTYPE  5'd4
`define LTYPE  5'd5
`define UTYPE  5'd6
`define JTYPE  5'd7
`define JRTYPE 5'd8
`endif

module writeback #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMR_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [4:0]  itype_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] alu_result_i,
  input  logic [19:0] imm_i,
  input  logic [31:0] pc_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] wd_o,
  output logic [4:0]  wd_addr_o,
  output logic        wd_q_o,
  output logic        err_o
`ifdef WB_FORWARD_EN
  ,
  output logic        fwd_valid_o,
  output logic [4:0]  fwd_rd_o,
  output logic [31:0] fwd_data_o
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, SETUP, STROBE} state_t;

  state_t             state;
  logic [4:0]         cap_rd;
  logic [2:0]         cap_funct3;
  logic [1:0]         cap_addr_lo;
  logic [31:0]        value;
  logic [TMR_W-1:0]   timer;
  logic [TMR_W:0]     tmr_inc;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [31:0]        load_val;
  logic               load_bad;

  assign ready_o = (state == IDLE);
  // widened by one bit so the compare against MEM_TIMEOUT can never wrap
  assign tmr_inc = {1'b0, timer} + 1'b1;

`ifdef WB_FORWARD_EN
  assign fwd_valid_o = (state == SETUP) || (state == STROBE);
  assign fwd_rd_o    = fwd_valid_o ? cap_rd : 5'd0;
  assign fwd_data_o  = fwd_valid_o ? value : 32'd0;
`endif

  // lane selection and size/sign extension of the returning load word
  always_comb begin
    byte_sel = mem_data_i[8*cap_addr_lo +: 8];
    half_sel = cap_addr_lo[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    load_val = 32'd0;
    load_bad = 1'b0;
    case (cap_funct3)
      3'b000: load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100: load_val = {24'd0, byte_sel};
      3'b001: begin
        load_val = {{16{half_sel[15]}}, half_sel};
        load_bad = cap_addr_lo[0];
      end
      3'b101: begin
        load_val = {16'd0, half_sel};
        load_bad = cap_addr_lo[0];
      end
      3'b010: begin
        load_val = mem_data_i;
        load_bad = (cap_addr_lo != 2'd0);
      end
      default: load_bad = 1'b1;
    endcase
  end

  // control FSM with registered write-port and error outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cap_rd      <= 5'd0;
      cap_funct3  <= 3'd0;
      cap_addr_lo <= 2'd0;
      value       <= 32'd0;
      timer       <= '0;
      wd_o        <= 32'd0;
      wd_addr_o   <= 5'd0;
      wd_q_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      wd_q_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            cap_rd      <= rd_i;
            cap_funct3  <= funct3_i;
            cap_addr_lo <= addr_lo_i;
            case (itype_i)
              `RTYPE, `ITYPE: begin
                value <= alu_result_i;
                if (rd_i != 5'd0) state <= SETUP;
              end
              `UTYPE: begin
                value <= {imm_i, 12'b0};
                if (rd_i != 5'd0) state <= SETUP;
              end
              `JTYPE, `JRTYPE: begin
                value <= pc_i + 32'd4;
                if (rd_i != 5'd0) state <= SETUP;
              end
              // a load to x0 still waits for its data so the memory handshake completes
              `LTYPE: begin
                timer <= '0;
                state <= WAIT_MEM;
              end
              default: ;
            endcase
          end
        end
        WAIT_MEM: begin
          // returning data takes priority over a timeout on the same edge
          if (mem_valid_i) begin
            if (load_bad) begin
              err_o <= 1'b1;
              state <= IDLE;
            end else if (cap_rd != 5'd0) begin
              value <= load_val;
              state <= SETUP;
            end else begin
              state <= IDLE;
            end
          end else if (tmr_inc == (TMR_W+1)'(MEM_TIMEOUT)) begin
            err_o <= 1'b1;
            state <= IDLE;
          end else begin
            timer <= tmr_inc[TMR_W-1:0];
          end
        end
        SETUP: begin
          wd_o      <= value;
          wd_addr_o <= cap_rd;
          state     <= STROBE;
        end
        STROBE: begin
          wd_q_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback.sv
// tb/tb_writeback.sv - self-checking bench for writeback: vector table, directed sequences, random vs model

`ifndef RTYPE
`define RTYPE  5'd1
`define ITYPE  5'd2
`define STYPE  5'd3
`define BTYPE  5'd4
`define LTYPE  5'd5
`define UTYPE  5'd6
`define JTYPE  5'd7
`define JRTYPE 5'd8
`endif

module tb_writeback;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  itype_i;
  logic [4:0]  rd_i;
  logic [31:0] alu_result_i;
  logic [19:0] imm_i;
  logic [31:0] pc_i;
  logic [2:0]  funct3_i;
  logic [1:0]  addr_lo_i;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;
  logic [31:0] wd_o;
  logic [4:0]  wd_addr_o;
  logic        wd_q_o;
  logic        err_o;
`ifdef WB_FORWARD_EN
  logic        fwd_valid_o;
  logic [4:0]  fwd_rd_o;
  logic [31:0] fwd_data_o;
`endif

  writeback #(.MEM_TIMEOUT(TMO), .TMR_W(8)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .itype_i(itype_i), .rd_i(rd_i), .alu_result_i(alu_result_i), .imm_i(imm_i),
    .pc_i(pc_i), .funct3_i(funct3_i), .addr_lo_i(addr_lo_i),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
    .wd_o(wd_o), .wd_addr_o(wd_addr_o), .wd_q_o(wd_q_o), .err_o(err_o)
`ifdef WB_FORWARD_EN
    , .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  itype;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [19:0] imm;
    logic [31:0] pc;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] mem;
    int          delay;
    bit          mem_en;
    bit          exp_w;
    bit          exp_e;
    logic [31:0] exp_d;
    int          exp_k;
  } vec_t;

  int tests = 0;
  int failed = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] it, input logic [4:0] rd, input logic [31:0] alu,
                              input logic [19:0] imm, input logic [31:0] pc, input logic [2:0] f3,
                              input logic [1:0] alo, input logic [31:0] mem, input int d, input bit en,
                              input bit w, input bit e, input logic [31:0] data, input int k);
    vec_t v;
    v.itype = it; v.rd = rd; v.alu = alu; v.imm = imm; v.pc = pc; v.f3 = f3; v.alo = alo;
    v.mem = mem; v.delay = d; v.mem_en = en; v.exp_w = w; v.exp_e = e; v.exp_d = data; v.exp_k = k;
    return v;
  endfunction

  // reference model: write/err/value and the sample index at which the stage is idle again
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic [31:0] b, h;
    bit bad;
    r.exp_w = 0; r.exp_e = 0; r.exp_d = 0; r.exp_k = 0;
    if (v.itype == `RTYPE || v.itype == `ITYPE) begin
      r.exp_d = v.alu; r.exp_w = (v.rd != 0);
    end else if (v.itype == `UTYPE) begin
      r.exp_d = 32'(v.imm) * 32'd4096; r.exp_w = (v.rd != 0);
    end else if (v.itype == `JTYPE || v.itype == `JRTYPE) begin
      r.exp_d = v.pc + 32'd4; r.exp_w = (v.rd != 0);
    end else if (v.itype == `LTYPE) begin
      if (!v.mem_en) begin
        r.exp_e = 1; r.exp_k = TMO;
        return r;
      end
      b = (v.mem >> (8 * int'(v.alo))) & 32'hFF;
      h = (v.mem >> (16 * (int'(v.alo) / 2))) & 32'hFFFF;
      bad = 0;
      case (v.f3)
        3'd0: r.exp_d = (b >= 128) ? b - 32'd256 : b;
        3'd4: r.exp_d = b;
        3'd1: begin r.exp_d = (h >= 32768) ? h - 32'd65536 : h; bad = (v.alo % 2) != 0; end
        3'd5: begin r.exp_d = h; bad = (v.alo % 2) != 0; end
        3'd2: begin r.exp_d = v.mem; bad = (v.alo != 0); end
        default: bad = 1;
      endcase
      if (bad) begin
        r.exp_e = 1; r.exp_d = 0; r.exp_k = v.delay + 1;
      end else begin
        r.exp_w = (v.rd != 0); r.exp_k = r.exp_w ? v.delay + 3 : v.delay + 1;
      end
      return r;
    end
    r.exp_k = r.exp_w ? 2 : 0;
    return r;
  endfunction

  task automatic run(input string tag, input vec_t v);
    int k, done_k, strobes, errs;
    logic [31:0] sd, pre, prev_wd;
    logic [4:0] sa;
    sd = 0; pre = 0; sa = 0;
    chk({tag, ":ready_before"}, 32'(ready_o), 32'd1);
    itype_i = v.itype; rd_i = v.rd; alu_result_i = v.alu; imm_i = v.imm; pc_i = v.pc;
    funct3_i = v.f3; addr_lo_i = v.alo; mem_data_i = v.mem; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    k = 0; done_k = -1; strobes = 0; errs = 0; prev_wd = wd_o;
    while (k <= 400) begin
      if (wd_q_o) begin strobes++; sd = wd_o; sa = wd_addr_o; pre = prev_wd; end
      if (err_o) errs++;
      if (ready_o && done_k < 0) done_k = k;
      if (done_k >= 0 && k > done_k) break;
      mem_valid_i = (v.itype == `LTYPE) && v.mem_en && (k == v.delay);
      prev_wd = wd_o;
      step();
      k++;
    end
    mem_valid_i = 1'b0;
    chk({tag, ":done_cycle"}, 32'(done_k), 32'(v.exp_k));
    chk({tag, ":strobes"}, 32'(strobes), 32'(v.exp_w));
    chk({tag, ":err_pulses"}, 32'(errs), 32'(v.exp_e));
    if (v.exp_w) begin
      chk({tag, ":wd"}, sd, v.exp_d);
      chk({tag, ":wd_addr"}, 32'(sa), 32'(v.rd));
      chk({tag, ":wd_before_strobe"}, pre, v.exp_d);
    end
  endtask

  localparam logic [31:0] M = 32'h80FF_7F01;

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [4:0] codes [9];
    int n;

    codes = '{`RTYPE, `ITYPE, `STYPE, `BTYPE, `LTYPE, `UTYPE, `JTYPE, `JRTYPE, 5'd20};
    reset = 1'b0; valid_i = 0; itype_i = 0; rd_i = 0; alu_result_i = 0; imm_i = 0; pc_i = 0;
    funct3_i = 0; addr_lo_i = 0; mem_valid_i = 0; mem_data_i = 0;

    // reset state and idle quiet period
    step(); step();
    chk("rst:wd", wd_o, 32'd0);
    chk("rst:wd_addr", 32'(wd_addr_o), 32'd0);
    chk("rst:wd_q", 32'(wd_q_o), 32'd0);
    chk("rst:err", 32'(err_o), 32'd0);
    reset = 1'b1;
    step();
    chk("rst:ready", 32'(ready_o), 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (wd_q_o || err_o || !ready_o) n++;
      step();
    end
    chk("idle20:activity", 32'(n), 32'd0);

    //          itype    rd  alu           imm       pc            f3 alo mem d  en w e data          k
    tbl.push_back(mk(`RTYPE,  5, 32'h12345678, 20'h0,    32'h0,        0, 0, M, 0, 1, 1, 0, 32'h12345678, 2));
    tbl.push_back(mk(`UTYPE,  3, 32'h0,        20'hABCDE, 32'h0,       0, 0, M, 0, 1, 1, 0, 32'hABCDE000, 2));
    tbl.push_back(mk(`JTYPE,  1, 32'h0,        20'h0,    32'hFFFFFFFC, 0, 0, M, 0, 1, 1, 0, 32'h00000000, 2));
    tbl.push_back(mk(`JRTYPE, 31, 32'h0,       20'h0,    32'h00001000, 0, 0, M, 0, 1, 1, 0, 32'h00001004, 2));
    tbl.push_back(mk(`ITYPE,  2, 32'hDEADBEEF, 20'h0,    32'h0,        0, 0, M, 0, 1, 1, 0, 32'hDEADBEEF, 2));
    tbl.push_back(mk(`LTYPE,  4, 32'h0,        20'h0,    32'h0,        0, 3, M, 0, 1, 1, 0, 32'hFFFFFF80, 3));
    tbl.push_back(mk(`LTYPE,  6, 32'h0,        20'h0,    32'h0,        4, 3, M, 2, 1, 1, 0, 32'h00000080, 5));
    tbl.push_back(mk(`LTYPE,  8, 32'h0,        20'h0,    32'h0,        0, 1, M, 1, 1, 1, 0, 32'h0000007F, 4));
    tbl.push_back(mk(`LTYPE,  9, 32'h0,        20'h0,    32'h0,        1, 2, M, 0, 1, 1, 0, 32'hFFFF80FF, 3));
    tbl.push_back(mk(`LTYPE, 10, 32'h0,        20'h0,    32'h0,        5, 0, M, 0, 1, 1, 0, 32'h00007F01, 3));
    tbl.push_back(mk(`LTYPE, 11, 32'h0,        20'h0,    32'h0,        2, 0, M, 1, 1, 1, 0, 32'h80FF7F01, 4));
    tbl.push_back(mk(`LTYPE, 12, 32'h0,        20'h0,    32'h0,        2, 1, M, 0, 1, 0, 1, 32'h0, 1));
    tbl.push_back(mk(`LTYPE, 13, 32'h0,        20'h0,    32'h0,        1, 1, M, 2, 1, 0, 1, 32'h0, 3));
    tbl.push_back(mk(`LTYPE, 14, 32'h0,        20'h0,    32'h0,        3, 0, M, 0, 1, 0, 1, 32'h0, 1));
    tbl.push_back(mk(`STYPE,  5, 32'h11111111, 20'h0,    32'h0,        0, 0, M, 0, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(`BTYPE,  5, 32'h11111111, 20'h0,    32'h0,        0, 0, M, 0, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(5'd20,   5, 32'h11111111, 20'h0,    32'h0,        0, 0, M, 0, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(`RTYPE,  0, 32'h22222222, 20'h0,    32'h0,        0, 0, M, 0, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(`LTYPE,  0, 32'h0,        20'h0,    32'h0,        2, 0, M, 1, 1, 0, 0, 32'h0, 2));
    tbl.push_back(mk(`LTYPE,  7, 32'h0,        20'h0,    32'h0,        2, 0, M, 0, 0, 0, 1, 32'h0, TMO));
    tbl.push_back(mk(`RTYPE, 15, 32'hCAFEF00D, 20'h0,    32'h0,        0, 0, M, 0, 1, 1, 0, 32'hCAFEF00D, 2));
    tbl.push_back(mk(`LTYPE, 16, 32'h0,        20'h0,    32'h0,        2, 0, M, TMO-1, 1, 1, 0, 32'h80FF7F01, TMO+2));
    tbl.push_back(mk(`LTYPE, 17, 32'h0,        20'h0,    32'h0,        4, 2, M, TMO-2, 1, 1, 0, 32'h000000FF, TMO+1));

    foreach (tbl[i]) run($sformatf("vec%0d", i), tbl[i]);

    // reset while waiting for memory: the load is dropped and later data is ignored
    itype_i = `LTYPE; rd_i = 5'd9; funct3_i = 3'd2; addr_lo_i = 2'd0; mem_data_i = M; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step(); step();
    chk("rstmid:busy", 32'(ready_o), 32'd0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rstmid:ready", 32'(ready_o), 32'd1);
    chk("rstmid:wd", wd_o, 32'd0);
    mem_valid_i = 1'b1;
    step();
    mem_valid_i = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (wd_q_o || err_o || !ready_o) n++;
      step();
    end
    chk("rstmid:no_activity", 32'(n), 32'd0);

    // randomized transactions against the model
    for (int i = 0; i < 60; i++) begin
      v = mk(codes[$urandom_range(0, 8)], 5'($urandom_range(1, 31)), $urandom, 20'($urandom),
             $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom,
             $urandom_range(0, 5), 1, 0, 0, 0, 0);
      v = model(v);
      run($sformatf("rnd%0d", i), v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/writeback.md
Name: writeback

Overview:
- Write-back stage; the writer end of the register-file write port that the decode stage reads.
- Takes a retired result from execute and selects or forms the destination value:
  - ALU result
  - U-type immediate
  - link address
  - load data, extended by size and sign
- Presents the value, destination index and a one-cycle write strobe (wd_o / wd_addr_o / wd_q_o).
- Decode latches the write on the rising edge of wd_q_o, so data and address are stable one cycle before the strobe and during it.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles to wait in WAIT_MEM for mem_valid_i before the load is aborted.
- TMR_W, 8: width of the timeout counter; MEM_TIMEOUT must be < 2^TMR_W.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- valid_i  in  1  execute presents a retiring instruction.
- ready_o  out  1  writeback can accept; transfer occurs when valid_i && ready_o.
- itype_i  in  5  instruction class (`RTYPE/`ITYPE/`STYPE/`BTYPE/`LTYPE/`UTYPE/`JTYPE/`JRTYPE).
- rd_i  in  5  destination register index.
- alu_result_i  in  32  ALU result (R/I types).
- imm_i  in  20  U-type upper immediate.
- pc_i  in  32  PC of the instruction (link = pc_i + 4).
- funct3_i  in  3  load size/sign code.
- addr_lo_i  in  2  load byte address bits [1:0].
- mem_valid_i  in  1  load data valid from memory.
- mem_data_i  in  32  load word (aligned).
- wd_o  out  32  write data to register file.
- wd_addr_o  out  5  write destination index.
- wd_q_o  out  1  write strobe, one-cycle pulse.
- err_o  out  1  one-cycle pulse on misaligned load, illegal funct3 or memory timeout.

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE; wd_o=0, wd_addr_o=0, wd_q_o=0, err_o=0.
  - Timer=0; captured fields cleared.
  - ready_o=1 after reset releases.
  - Reset mid-operation discards any pending load and write; no strobe issues. A later mem_valid_i is ignored.
- States: IDLE, WAIT_MEM, SETUP, STROBE. ready_o=1 only in IDLE.
- IDLE, on accept, capture itype, rd, funct3, addr_lo, then by class:
  - `RTYPE/`ITYPE: value = alu_result_i → SETUP.
  - `UTYPE: value = {imm_i, 12'b0} → SETUP.
  - `JTYPE/`JRTYPE: value = pc_i + 32'd4, modulo 2^32 → SETUP.
  - `LTYPE: → WAIT_MEM; timer cleared.
  - `STYPE/`BTYPE or unknown class: no write; stay IDLE.
  - rd_i==0 on any class: no write, no strobe, stay IDLE. A load with rd=0 still waits for mem_valid_i, then returns to IDLE without a strobe.
- WAIT_MEM:
  - Timer increments each cycle.
  - On mem_valid_i, select and extend the load data:
    - funct3 000 LB: byte at lane addr_lo, sign-extended.
    - funct3 100 LBU: byte at lane addr_lo, zero-extended.
    - funct3 001 LH / 101 LHU: halfword at addr_lo[1]; sign- or zero-extended.
    - funct3 010 LW: full word.
    - Then → SETUP.
  - Misaligned access (LH/LHU with addr_lo[0]=1, or LW with addr_lo≠0) or illegal funct3: err_o pulse, no write → IDLE.
  - Timer reaches MEM_TIMEOUT without mem_valid_i: err_o pulse, no write → IDLE.
  - mem_valid_i and timer expiry in the same cycle: the data wins.
- SETUP: drive wd_o and wd_addr_o, wd_q_o=0 → STROBE.
- STROBE: wd_q_o=1 with wd_o and wd_addr_o held → IDLE. wd_o and wd_addr_o stay held until the next SETUP.
- Latency:
  - Non-load accepted at edge N: data valid after N+1, strobe high during cycle after N+2.
  - Load: strobe two cycles after the mem_valid_i edge.
- Throughput: one write per 3 cycles.
- mem_valid_i outside WAIT_MEM is ignored.

Optional Feature:
- Macro: WB_FORWARD_EN.
- When defined, add three outputs:
  - fwd_valid_o (1): high in SETUP and STROBE when a write is pending.
  - fwd_rd_o (5): the pending destination index.
  - fwd_data_o (32): the pending value.
  - Execute uses these to bypass register-file reads.
  - All three reset to 0.
- When undefined, these ports do not exist and behaviour is otherwise identical.

Test Plan:
- Reset low 2 cycles, then high → all outputs 0, ready_o=1; no wd_q_o pulse for 20 idle cycles.
- `RTYPE, rd=5, alu_result=32'h1234_5678 → wd_addr_o=5, wd_o=32'h12345678; wd_q_o high exactly one cycle, 2 cycles after accept; ready_o low for 2 cycles.
- `UTYPE imm=20'hABCDE rd=3 → wd_o=32'hABCDE000. `JTYPE pc=32'hFFFF_FFFC rd=1 → wd_o=0 (wrap).
- Loads with mem_data=32'h80FF_7F01:
  - LB addr_lo=3 → FFFFFF80.
  - LBU addr_lo=3 → 00000080.
  - LH addr_lo=2 → FFFF80FF.
  - LHU addr_lo=0 → 00007F01.
  - LW addr_lo=1 → err_o pulse, no strobe.
- `LTYPE rd=7 with no mem_valid_i → err_o pulse MEM_TIMEOUT cycles after accept; back to IDLE; no write. Next instruction accepted normally.
- `STYPE or rd=0 `RTYPE → no wd_q_o. Reset asserted while in WAIT_MEM, then mem_valid_i → no strobe, ready_o=1.
